// File: rtl/fpu_issue_controller_pkg.sv
// Shared definitions for the FPU issue controller: op codes, flag layout, FSM states, latency lookup.
package fpu_pkg;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;
   localparam logic [2:0] OP_RND = 3'd5;
   localparam logic [2:0] OP_SLT = 3'd6;
   localparam logic [2:0] OP_INV = 3'd7;

   localparam int FLG_DZ   = 5;
   localparam int FLG_QNAN = 4;
   localparam int FLG_SNAN = 3;
   localparam int FLG_NX   = 2;
   localparam int FLG_UF   = 1;
   localparam int FLG_OF   = 0;

   localparam int CNT_W = 8;

   typedef logic [5:0] fp_flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] op_latency(input logic [2:0] op,
                                                   input int lat_add,
                                                   input int lat_mul,
                                                   input int lat_div,
                                                   input int lat_misc);
      int lat;
      case (op)
         OP_ADD, OP_SUB: lat = lat_add;
         OP_MUL:         lat = lat_mul;
         OP_DIV:         lat = lat_div;
         default:        lat = lat_misc;
      endcase
      return CNT_W'(lat);
   endfunction

endpackage

// File: rtl/fpu_issue_controller_if.sv
// Request, response and ALU-side signals of the FPU issue controller.
// master = requesters + ALU (bench side), slave = controller.
interface fpu_issue_controller_if;
   import fpu_pkg::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][2:0]   req_op;
   logic [1:0][31:0]  req_a;
   logic [1:0][31:0]  req_b;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [31:0]       rsp_data;
   fp_flags_t         rsp_flags;

   logic [31:0]       alu_in1;
   logic [31:0]       alu_in2;
   logic [2:0]        alu_op;
   logic [31:0]       alu_result;
   fp_flags_t         alu_flags;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, alu_in1, alu_in2, alu_op
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, alu_in1, alu_in2, alu_op
   );

endinterface

// File: rtl/fpu_issue_controller_rr_arbiter.sv
// Two-way round-robin arbiter: the requester named by ptr wins ties.
module fpu_rr_arbiter (
   input  logic       en,
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       idx,
   output logic       valid
);

   always_comb begin
      valid = en && (|req);
      idx   = req[ptr] ? ptr : ~ptr;
      grant = 2'b00;
      if (valid) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_issue_controller.sv
// Shares one combinational FP ALU between two requesters with multi-cycle settle and sticky flags.
// Optional trap output is enabled by defining FPU_ISSUE_TRAP_EN.
module fpu_issue_controller
   import fpu_pkg::*;
#(
   parameter int LAT_ADD  = 2,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 8,
   parameter int LAT_MISC = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fpu_issue_controller_if.slave  bus,
   output fp_flags_t              sticky_flags,
   input  logic                   sticky_clr,
   output logic                   busy
`ifdef FPU_ISSUE_TRAP_EN
   ,
   input  fp_flags_t              trap_mask,
   output logic                   trap,
   output logic                   trap_id
`endif
);

   if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1 || LAT_MISC < 1) begin : g_lat_min_check
      $error("fpu_issue_controller: every LAT parameter must be at least 1");
   end
   if (LAT_ADD > (1 << CNT_W) || LAT_MUL > (1 << CNT_W) ||
       LAT_DIV > (1 << CNT_W) || LAT_MISC > (1 << CNT_W)) begin : g_lat_max_check
      $error("fpu_issue_controller: a LAT parameter exceeds the settle counter range");
   end

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic              id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   fp_flags_t         rsp_flags_q, rsp_flags_d;
   fp_flags_t         sticky_q, sticky_d;
   logic              capture;

   logic [1:0]        arb_grant;
   logic              arb_idx;
   logic              arb_valid;

   fpu_rr_arbiter u_arb (
      .en    (state_q == IDLE),
      .req   (bus.req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Grant is visible in the same cycle; everything the ALU sees comes from latched copies.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      sticky_d    = sticky_clr ? '0 : sticky_q;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               op_d    = bus.req_op[arb_idx];
               a_d     = bus.req_a[arb_idx];
               b_d     = bus.req_b[arb_idx];
               id_d    = arb_idx;
               cnt_d   = op_latency(bus.req_op[arb_idx], LAT_ADD, LAT_MUL, LAT_DIV, LAT_MISC)
                         - CNT_W'(1);
               ptr_d   = ~arb_idx;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               capture     = 1'b1;
               rsp_data_d  = bus.alu_result;
               rsp_flags_d = bus.alu_flags;
               rsp_valid_d = 1'b1;
               sticky_d    = sticky_d | bus.alu_flags;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef FPU_ISSUE_TRAP_EN
   logic trap_q, trap_d;
   logic trap_id_q, trap_id_d;

   always_comb begin
      trap_d    = 1'b0;
      trap_id_d = trap_id_q;
      if (capture) begin
         trap_d = |(bus.alu_flags & trap_mask);
         if (trap_d) begin
            trap_id_d = id_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q    <= 1'b0;
         trap_id_q <= 1'b0;
      end else begin
         trap_q    <= trap_d;
         trap_id_q <= trap_id_d;
      end
   end

   assign trap    = trap_q;
   assign trap_id = trap_id_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         cnt_q       <= '0;
         op_q        <= OP_NOP;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         sticky_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.req_ready = arb_grant;
   assign bus.alu_in1   = a_q;
   assign bus.alu_in2   = b_q;
   assign bus.alu_op    = op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign sticky_flags  = sticky_q;
   assign busy          = (state_q != IDLE);

endmodule
